// File: rtl/lfsr_hist_pkg.sv
// Shared definitions for the LFSR histogram engine: FSM encoding, default taps, bin-width helper.
package lfsr_hist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DUMP  = 2'd3;

    // Maximal-length Galois mask for an 8-bit right-shifting LFSR.
    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;

    function automatic int bin_w(input int num_bins);
        return (num_bins <= 1) ? 1 : $clog2(num_bins);
    endfunction

endpackage

// File: rtl/lfsr_hist_engine_lfsr.sv
// Right-shifting Galois LFSR with seed load; a zero seed would lock up, so it is replaced by 1.
module lfsr_galois #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= LFSR_W'(1);
        end else if (load) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/lfsr_hist_engine.sv
// LFSR-driven histogram engine: clear bins, accumulate LFSR samples, stream bin counts on AXI-Stream.
//   state    | meaning
//   ST_IDLE  | waiting for cfg_start
//   ST_CLEAR | zeroing one bin per cycle
//   ST_ACCUM | binning one LFSR sample per cycle
//   ST_DUMP  | streaming bin counts, one beat per bin
module lfsr_hist_engine
    import lfsr_hist_pkg::*;
#(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
    parameter int                NUM_BINS  = 4,
    parameter int                CNT_W     = 16,
    parameter int                SAMP_W    = 16,
    parameter int                DATA_W    = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_start,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [SAMP_W-1:0] cfg_num_samp,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int               BIN_W    = bin_w(NUM_BINS);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    logic [1:0]        state;
    logic [BIN_W-1:0]  idx;
    logic [BIN_W-1:0]  idx_nxt;
    logic [BIN_W-1:0]  bin_sel;
    logic [SAMP_W-1:0] samp_left;
    logic [CNT_W-1:0]  cnt [NUM_BINS];
    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_load;
    logic              lfsr_step;

    assign lfsr_load = (state == ST_IDLE) && cfg_start;
    assign lfsr_step = (state == ST_ACCUM);
    assign idx_nxt   = idx + 1'b1;
    assign bin_sel   = BIN_W'(lfsr_state >> (LFSR_W - BIN_W));

    lfsr_galois #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (lfsr_load),
        .seed    (cfg_seed),
        .step    (lfsr_step),
        .state   (lfsr_state)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            samp_left     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            for (int i = 0; i < NUM_BINS; i++) cnt[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        samp_left <= cfg_num_samp;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt[idx] <= '0;
                    idx      <= idx_nxt;
                    if (idx == LAST_BIN) begin
                        idx   <= '0;
                        state <= (samp_left == '0) ? ST_DUMP : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (cnt[bin_sel] != '1) cnt[bin_sel] <= cnt[bin_sel] + 1'b1;
                    samp_left <= samp_left - 1'b1;
                    if (samp_left == SAMP_W'(1)) state <= ST_DUMP;
                end
                ST_DUMP: begin
                    // First DUMP cycle loads beat 0; later beats load on each handshake.
                    if (!m_axis_tvalid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= DATA_W'(cnt[idx]);
                        m_axis_tlast  <= (idx == LAST_BIN);
                    end else if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            idx          <= idx_nxt;
                            m_axis_tdata <= DATA_W'(cnt[idx_nxt]);
                            m_axis_tlast <= (idx_nxt == LAST_BIN);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
